// File: rtl/stream_skid_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : stream_skid_fifo_if
//  Description : Port bundle for the stream_skid_fifo elastic buffer.
//                Carries the upstream VALID/BP pair, the downstream
//                VALID/BP pair and the status outputs (level, overflow,
//                activity).
//                  d        upstream data
//                  d_valid  upstream word valid
//                  d_bp     back-pressure to upstream
//                  q        downstream data
//                  q_valid  downstream word valid
//                  q_bp     back-pressure from downstream
//                  level    current occupancy
//                  ovf      sticky overflow flag
//                  act      stretched activity indicator
//                master : the side that produces into and consumes from the FIFO
//                slave  : the FIFO itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface stream_skid_fifo_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
);
    localparam int c_LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic             d_bp;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             q_bp;
    logic [c_LW-1:0]  level;
    logic             ovf;
    logic             act;

    modport master (
        output d, d_valid, q_bp,
        input  d_bp, q, q_valid, level, ovf, act
    );

    modport slave (
        input  d, d_valid, q_bp,
        output d_bp, q, q_valid, level, ovf, act
    );
endinterface
`default_nettype wire

// File: rtl/stream_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : stream_skid_fifo
//  Description : Elastic buffer for one router port. A circular buffer
//                decouples the producer from router back-pressure; the
//                upstream back-pressure is raised early enough to leave
//                SLACK words of margin. Also reports occupancy, a sticky
//                overflow flag and a stretched activity pulse for an LED.
//  Ports       : clk    single clock
//                rst_n  asynchronous active-low reset
//                bus    stream_skid_fifo_if.slave
//                       (d, d_valid, d_bp, q, q_valid, q_bp, level, ovf, act)
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_fifo #(
    parameter int WIDTH       = 64,
    parameter int DEPTH       = 16,
    parameter int SLACK       = 4,
    parameter int ACT_STRETCH = 1023
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    stream_skid_fifo_if.slave  bus
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_SW = $clog2(ACT_STRETCH + 1);

    localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_BP_THR  = c_CW'(DEPTH - SLACK);
    localparam logic [c_SW-1:0] c_STRETCH = c_SW'(ACT_STRETCH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic             r_d_bp;
    logic             r_ovf;
    logic [c_SW-1:0]  r_act_cnt;

    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [c_CW-1:0]  w_next_count;

    // A pop on the same edge frees a slot, so a push into a full buffer
    // is only dropped when nothing leaves on that edge.
    always_comb begin
        w_full       = (r_count == c_FULL);
        w_pop        = (r_count != '0) && !bus.q_bp;
        w_push       = bus.d_valid && (!w_full || w_pop);
        w_drop       = bus.d_valid && w_full && !w_pop;
        w_next_count = r_count + c_CW'(w_push) - c_CW'(w_pop);
    end

    // Storage has no reset; stale contents are unreachable once the
    // pointers clear.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_d_bp    <= 1'b1;
            r_ovf     <= 1'b0;
            r_act_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end

            // Pop reads the pre-edge entry; a same-edge write to the same
            // slot lands afterwards, so there is no write-through.
            if (w_pop) begin
                r_q      <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_q_valid <= w_pop;

            r_count <= w_next_count;
            r_d_bp  <= (w_next_count >= c_BP_THR);

            if (w_drop) begin
                r_ovf <= 1'b1;
            end

            if (w_push || w_pop) begin
                r_act_cnt <= c_STRETCH;
            end else if (r_act_cnt != '0) begin
                r_act_cnt <= r_act_cnt - c_SW'(1);
            end
        end
    end

    assign bus.q       = r_q;
    assign bus.q_valid = r_q_valid;
    assign bus.d_bp    = r_d_bp;
    assign bus.level   = r_count;
    assign bus.ovf     = r_ovf;
    assign bus.act     = (r_act_cnt != '0);

endmodule
`default_nettype wire
